// File: rtl/sr_command_gen.sv
// sr_command_gen: synchronises and debounces two push-buttons and turns each accepted
// press into a fixed-width, never-overlapping S or R pulse. Option macro: SR_CMD_SHADOW_EN.
module sr_command_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_WIDTH     = 2,
   parameter int GAP_CYCLES      = 1
) (
   input  logic CLK_in,
   input  logic RST_in,
   input  logic SET_BTN_in,
   input  logic CLR_BTN_in,
   output logic S_out,
   output logic R_out,
   output logic BUSY_out,
   output logic CONFLICT_out
`ifdef SR_CMD_SHADOW_EN
   ,
   output logic Q_SHADOW_out
`endif
);

   typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR} cmd_t;

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TMR_W = $clog2(PULSE_WIDTH + GAP_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] PW_LAST  = TMR_W'(PULSE_WIDTH - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Bit 0 carries the set button, bit 1 the clear button.
   logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]       stable_q, stable_d, stable_prev_q, stable_prev_d;
   logic [DB_W-1:0]  db_cnt_q [2];
   logic [DB_W-1:0]  db_cnt_d [2];
   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   cmd_t             pend_q, pend_d;
   logic             s_out_q, s_out_d, r_out_q, r_out_d;
   logic             busy_q, busy_d, conflict_q, conflict_d;
   logic             req_set, req_clr, decide;
   cmd_t             req_cmd, next_cmd;
`ifdef SR_CMD_SHADOW_EN
   logic             shadow_q, shadow_d;
`endif

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      sync1_d       = {CLR_BTN_in, SET_BTN_in};
      sync2_d       = sync1_q;
      stable_prev_d = stable_q;
      stable_d      = stable_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) stable_d[i] = ~stable_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      req_set  = stable_q[0] & ~stable_prev_q[0];
      req_clr  = stable_q[1] & ~stable_prev_q[1];
      req_cmd  = CMD_NONE;
      if (req_set && !req_clr)      req_cmd = CMD_SET;
      else if (req_clr && !req_set) req_cmd = CMD_CLR;
      // A fresh request overrides the slot wherever a new command can be picked.
      next_cmd = (req_cmd != CMD_NONE) ? req_cmd : pend_q;
      state_d  = state_q;
      tmr_d    = tmr_q;
      pend_d   = pend_q;
      decide   = 1'b0;
`ifdef SR_CMD_SHADOW_EN
      shadow_d = shadow_q;
`endif
      case (state_q)
         IDLE: decide = 1'b1;
         PULSE_S, PULSE_R: begin
            if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
            else if (GAP_CYCLES > 0) begin
               state_d = GAP;
               tmr_d   = GAP_LAST;
            end else decide = 1'b1;
         end
         GAP: begin
            if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
            else             decide = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (decide) begin
         state_d = IDLE;
         pend_d  = CMD_NONE;
         tmr_d   = PW_LAST;
`ifdef SR_CMD_SHADOW_EN
         // Commands that would not change the flip-flop are dropped here.
         if (next_cmd == CMD_SET && !shadow_q) begin
            state_d  = PULSE_S;
            shadow_d = 1'b1;
         end else if (next_cmd == CMD_CLR && shadow_q) begin
            state_d  = PULSE_R;
            shadow_d = 1'b0;
         end
`else
         if (next_cmd == CMD_SET)      state_d = PULSE_S;
         else if (next_cmd == CMD_CLR) state_d = PULSE_R;
`endif
      end else if (req_cmd != CMD_NONE) begin
         pend_d = req_cmd;
      end

      s_out_d    = (state_d == PULSE_S);
      r_out_d    = (state_d == PULSE_R);
      busy_d     = (state_d != IDLE);
      conflict_d = req_set & req_clr;
   end

   always_ff @(posedge CLK_in) begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      if (RST_in) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
         state_q       <= IDLE;
         tmr_q         <= '0;
         pend_q        <= CMD_NONE;
         s_out_q       <= 1'b0;
         r_out_q       <= 1'b0;
         busy_q        <= 1'b0;
         conflict_q    <= 1'b0;
`ifdef SR_CMD_SHADOW_EN
         shadow_q      <= 1'b0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         db_cnt_q      <= db_cnt_d;
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         pend_q        <= pend_d;
         s_out_q       <= s_out_d;
         r_out_q       <= r_out_d;
         busy_q        <= busy_d;
         conflict_q    <= conflict_d;
`ifdef SR_CMD_SHADOW_EN
         shadow_q      <= shadow_d;
`endif
      end
   end

   assign S_out        = s_out_q;
   assign R_out        = r_out_q;
   assign BUSY_out     = busy_q;
   assign CONFLICT_out = conflict_q;
`ifdef SR_CMD_SHADOW_EN
   assign Q_SHADOW_out = shadow_q;
`endif

endmodule

// File: tb/tb_sr_command_gen.sv
// Self-checking bench for sr_command_gen: directed scenarios with hand-derived edge numbers,
// randomized button activity, and a per-cycle compare against a behavioural model.
module tb_sr_command_gen;

   localparam int D   = 4;
   localparam int PW  = 2;
   localparam int GAP = 1;

   logic clk = 1'b0;
   logic rst, set, clr, set2, clr2;
   logic s_o, r_o, busy_o, conf_o;
   logic s2_o, r2_o, busy2_o, conf2_o;
`ifdef SR_CMD_SHADOW_EN
   logic q_o, q2_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int n_edges = 0;
   int w_s_hi, w_s_rise, w_r_hi, w_r_rise, w_c_hi;

   always #5 clk = ~clk;

   sr_command_gen dut (
      .CLK_in(clk), .RST_in(rst), .SET_BTN_in(set), .CLR_BTN_in(clr),
      .S_out(s_o), .R_out(r_o), .BUSY_out(busy_o), .CONFLICT_out(conf_o)
`ifdef SR_CMD_SHADOW_EN
      , .Q_SHADOW_out(q_o)
`endif
   );

   // A long pulse makes room for two debounced requests to land inside one busy window.
   sr_command_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(16), .GAP_CYCLES(1)) dut_long (
      .CLK_in(clk), .RST_in(rst), .SET_BTN_in(set2), .CLR_BTN_in(clr2),
      .S_out(s2_o), .R_out(r2_o), .BUSY_out(busy2_o), .CONFLICT_out(conf2_o)
`ifdef SR_CMD_SHADOW_EN
      , .Q_SHADOW_out(q2_o)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n_edges);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic watch_clear();
      w_s_hi = 0; w_s_rise = 0; w_r_hi = 0; w_r_rise = 0; w_c_hi = 0;
   endtask

   task automatic watch(input int n);
      logic ps, pr;
      ps = s_o;
      pr = r_o;
      repeat (n) begin
         tick();
         if (s_o) w_s_hi++;
         if (s_o && !ps) w_s_rise++;
         if (r_o) w_r_hi++;
         if (r_o && !pr) w_r_rise++;
         if (conf_o) w_c_hi++;
         ps = s_o;
         pr = r_o;
      end
   endtask

   // ---------------- behavioural model of the main instance ----------------
   // Commands: 0 none, 1 set, 2 clear. m_rem counts the busy cycles still to come.
   bit m_s1[2], m_s2[2], m_stab[2], m_prev[2];
   bit m_hist0[$], m_hist1[$];
   int m_slot = 0, m_kind = 0, m_rem = 0;
   bit m_conf = 0, m_shadow = 0;

   function automatic bit window_flips(input bit hist[$], input bit stab);
      if (hist.size() < D) return 1'b0;
      foreach (hist[k]) if (hist[k] == stab) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      n_edges++;
      if (rst) begin
         m_s1 = '{0, 0}; m_s2 = '{0, 0}; m_stab = '{0, 0}; m_prev = '{0, 0};
         m_hist0.delete(); m_hist1.delete();
         m_slot = 0; m_kind = 0; m_rem = 0; m_conf = 0; m_shadow = 0;
      end else begin
         bit rs, rc, redundant;
         int req, eff;
         rs = m_stab[0] && !m_prev[0];
         rc = m_stab[1] && !m_prev[1];
         m_conf = rs && rc;
         req = m_conf ? 0 : (rs ? 1 : (rc ? 2 : 0));
         if (m_rem <= 1) begin
            eff = (req != 0) ? req : m_slot;
            m_slot = 0; m_rem = 0; m_kind = 0;
            redundant = 1'b0;
`ifdef SR_CMD_SHADOW_EN
            redundant = (eff == 1 && m_shadow) || (eff == 2 && !m_shadow);
`endif
            if (eff != 0 && !redundant) begin
               m_kind = eff;
               m_rem = PW + GAP;
               m_shadow = (eff == 1);
            end
         end else begin
            m_rem--;
            if (req != 0) m_slot = req;
         end
         m_prev = m_stab;
         m_hist0.push_back(m_s2[0]);
         m_hist1.push_back(m_s2[1]);
         if (m_hist0.size() > D) void'(m_hist0.pop_front());
         if (m_hist1.size() > D) void'(m_hist1.pop_front());
         if (window_flips(m_hist0, m_stab[0])) begin m_stab[0] = !m_stab[0]; m_hist0.delete(); end
         if (window_flips(m_hist1, m_stab[1])) begin m_stab[1] = !m_stab[1]; m_hist1.delete(); end
         m_s2 = m_s1;
         m_s1[0] = set;
         m_s1[1] = clr;
      end
   end

   always @(negedge clk) begin
      if (n_edges > 0) begin
         check("model_S", s_o, (m_kind == 1 && m_rem > GAP));
         check("model_R", r_o, (m_kind == 2 && m_rem > GAP));
         check("model_BUSY", busy_o, (m_rem > 0));
         check("model_CONFLICT", conf_o, m_conf);
         check("never_S_and_R", s_o & r_o, 0);
`ifdef SR_CMD_SHADOW_EN
         check("model_SHADOW", q_o, m_shadow);
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int hold_s, hold_c;
      rst = 1'b1; set = 1'b0; clr = 1'b0; set2 = 1'b0; clr2 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_S", s_o, 0);
      check("rst_R", r_o, 0);
      check("rst_BUSY", busy_o, 0);
      check("rst_CONFLICT", conf_o, 0);
      rst = 1'b0;
      repeat (5) tick();

      // SET held for edges 0..9: pulse after edges 6 and 7, gap after edge 8.
      set = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("set_press_S", s_o, (i == 6 || i == 7));
         check("set_press_BUSY", busy_o, (i >= 6 && i <= 8));
         check("set_press_R", r_o, 0);
         if (i == 9) set = 1'b0;
      end
      repeat (15) tick();

      // Three-sample glitch is ignored; an eight-sample press gives one 2-cycle R pulse.
      clr = 1'b1;
      repeat (3) tick();
      clr = 1'b0;
      watch_clear();
      watch(15);
      check("glitch_R_hi", w_r_hi, 0);
      clr = 1'b1;
      watch_clear();
      watch(8);
      clr = 1'b0;
      watch(17);
      check("clr_press_R_hi", w_r_hi, 2);
      check("clr_press_R_rise", w_r_rise, 1);
      check("clr_press_S_hi", w_s_hi, 0);

      // Both buttons rise together: a single conflict flag after edge 6, no pulses.
      set = 1'b1; clr = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tick();
         check("both_CONFLICT", conf_o, (i == 6));
         check("both_S", s_o, 0);
         check("both_R", r_o, 0);
         if (i == 9) begin set = 1'b0; clr = 1'b0; end
      end
      repeat (10) tick();

      // Long-pulse instance: CLR queued at edge 13, SET overwrites at edge 14.
      set2 = 1'b1;
      for (int i = 0; i < 44; i++) begin
         tick();
`ifdef SR_CMD_SHADOW_EN
         check("overwrite_S", s2_o, (i >= 6 && i <= 21));
`else
         check("overwrite_S", s2_o, ((i >= 6 && i <= 21) || (i >= 23 && i <= 38)));
`endif
         check("overwrite_R", r2_o, 0);
         set2 = ((i + 1 <= 3) || (i + 1 >= 8 && i + 1 <= 11));
         clr2 = (i + 1 >= 7 && i + 1 <= 10);
      end

      // Reset sampled at edge 7 cuts the pulse; held button re-fires after edges 14 and 15.
      set = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("mid_reset_S", s_o, (i == 6 || i == 14 || i == 15));
         if (i == 6) rst = 1'b1;
         if (i == 7) rst = 1'b0;
         if (i == 18) set = 1'b0;
      end
      repeat (15) tick();

`ifdef SR_CMD_SHADOW_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("shadow_after_rst", q_o, 0);
      for (int p = 0; p < 3; p++) begin
         if (p < 2) set = 1'b1; else clr = 1'b1;
         watch_clear();
         watch(8);
         set = 1'b0; clr = 1'b0;
         watch(16);
         check("shadow_S_rise", w_s_rise, (p == 0));
         check("shadow_R_rise", w_r_rise, (p == 2));
         check("shadow_Q", q_o, (p < 2));
      end
`endif

      // Randomized button activity with occasional resets; the model checks every cycle.
      hold_s = 0;
      hold_c = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 599) == 0) rst = 1'b1;
         if ($urandom_range(0, 39) == 0) begin
            set = 1'b1; clr = 1'b1;
            hold_s = $urandom_range(4, 10);
            hold_c = hold_s;
         end else begin
            if (hold_s == 0) begin set = ~set; hold_s = $urandom_range(1, 14); end
            else hold_s--;
            if (hold_c == 0) begin clr = ~clr; hold_c = $urandom_range(1, 14); end
            else hold_c--;
         end
      end
      set = 1'b0; clr = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
